mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_pkg.sv | 25 ++
 rtl/mult_div_divider.sv | 77 +++++++
 rtl/mult_div.sv | 124 ++++++++++++
 tb/tb_mult_div.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// mult_div shared types and constants.
// Operation codes, FSM state and divide-context bundle.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_DIV_RUN = 1'b1
  } state_e;

  // Sign fix-up info captured when a division is accepted
  typedef struct packed {
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] a_raw;
  } div_ctx_t;

endpackage

// File: rtl/mult_div_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Quotient/remainder outputs are the values being written on the done edge.
module mult_div_divider
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] q_q, q_d;
  logic [31:0] d_q, d_d;
  logic [32:0] r_q, r_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [32:0] r_sh;
  logic [32:0] trial;
  logic [31:0] q_sh;

  assign r_sh  = {r_q[31:0], q_q[31]};
  assign trial = r_sh - {1'b0, d_q};
  assign q_sh  = {q_q[30:0], 1'b0};

  // Shift-subtract step and operand load
  always_comb begin
    q_d    = q_q;
    d_d    = d_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      q_d    = dividend;
      d_d    = divisor;
      r_d    = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!trial[32]) begin
        r_d = trial;
        q_d = q_sh | 32'd1;
      end else begin
        r_d = r_sh;
        q_d = q_sh;
      end
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(DIV_CYCLES - 1))
        busy_d = 1'b0;
    end
  end

  assign done      = busy_q && (cnt_q == 6'(DIV_CYCLES - 1));
  assign quotient  = q_d;
  assign remainder = r_d[31:0];

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      d_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      d_q    <= d_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/mult_div.sv
// Multiply / divide unit: single-cycle multiply, 32-cycle divide.
// Sign handling and multiplication live here; the divider is unsigned.
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] value_1,
  input  logic [31:0] value_2,
  input  logic [1:0]  operation,
  output logic [63:0] out,
  output logic        in_operation
);

  state_e      state_q, state_d;
  logic [63:0] out_q, out_d;
  logic        busy_q, busy_d;
  div_ctx_t    ctx_q, ctx_d;

  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] quo, rem;
  logic        div_done;

  logic [31:0] abs_a, abs_b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s;
  logic        is_mult, is_multu, is_div, is_divu;

  assign abs_a  = value_1[31] ? (~value_1 + 32'd1) : value_1;
  assign abs_b  = value_2[31] ? (~value_2 + 32'd1) : value_2;
  assign prod_s = {{32{value_1[31]}}, value_1}
                * {{32{value_2[31]}}, value_2};
  assign prod_u = {32'd0, value_1} * {32'd0, value_2};
  assign quo_s  = ctx_q.neg_q ? (~quo + 32'd1) : quo;
  assign rem_s  = ctx_q.neg_r ? (~rem + 32'd1) : rem;

  assign is_mult  = (operation == OP_MULT);
  assign is_multu = (operation == OP_MULTU);
  assign is_div   = (operation == OP_DIV);
  assign is_divu  = (operation == OP_DIVU);

  mult_div_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (div_a),
    .divisor   (div_b),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  // Accept requests in IDLE; write the fixed-up division result on done
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    busy_d    = busy_q;
    ctx_d     = ctx_q;
    div_start = 1'b0;
    div_a     = value_1;
    div_b     = value_2;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          unique case (1'b1)
            is_mult:  out_d = prod_s;
            is_multu: out_d = prod_u;
            is_div: begin
              div_start = 1'b1;
              div_a     = abs_a;
              div_b     = abs_b;
              ctx_d     = '{neg_q: value_1[31] ^ value_2[31],
                            neg_r: value_1[31],
                            dz:    (value_2 == 32'd0),
                            a_raw: value_1};
              state_d   = ST_DIV_RUN;
              busy_d    = 1'b1;
            end
            is_divu: begin
              div_start = 1'b1;
              ctx_d     = '{neg_q: 1'b0,
                            neg_r: 1'b0,
                            dz:    (value_2 == 32'd0),
                            a_raw: value_1};
              state_d   = ST_DIV_RUN;
              busy_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_DIV_RUN: begin
        if (div_done) begin
          out_d   = ctx_q.dz ? {ctx_q.a_raw, 32'hFFFF_FFFF}
                             : {rem_s, quo_s};
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      busy_q  <= 1'b0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ctx_q   <= ctx_d;
    end
  end

  assign out          = out_q;
  assign in_operation = busy_q;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div.
// Stimulus pushes expected results; a monitor pops and compares.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] value_1, value_2;
  logic [1:0]  operation;
  logic [63:0] out;
  logic        in_operation;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];

  mult_div dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .value_1      (value_1),
    .value_2      (value_2),
    .operation    (operation),
    .out          (out),
    .in_operation (in_operation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a mult result appears one edge after acceptance,
  // a division result when in_operation falls.
  logic        prev_busy = 1'b0;
  int          busy_cnt  = 0;
  logic [63:0] held      = '0;

  always @(posedge clk) begin
    logic acc_mul;
    logic [63:0] e;
    string nm;
    acc_mul = rst_n && enable && !in_operation && !operation[1];
    #1;
    if (!rst_n) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
      held      = out;
    end else begin
      if (acc_mul || (prev_busy && !in_operation)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got %h expected none", out);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk(nm, out, e);
          if (!acc_mul)
            chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        end
      end
      if (in_operation) begin
        busy_cnt++;
        chk("out_hold_while_busy", out, held);
      end else begin
        busy_cnt = 0;
      end
      if (acc_mul)
        chk("mult_no_busy", {63'd0, in_operation}, 64'd0);
      prev_busy = in_operation;
      if (!in_operation)
        held = out;
    end
  end

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (in_operation && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (in_operation) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: busy=%b expected 0", nm, in_operation);
    end
  endtask

  task automatic issue(input string nm, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    @(negedge clk);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    enable    = 1'b1;
    operation = op;
    value_1   = a;
    value_2   = b;
    @(negedge clk);
    enable = 1'b0;
    if (op[1]) begin
      chk({nm, "_busy_set"}, {63'd0, in_operation}, 64'd1);
      wait_idle(nm);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    enable    = 1'b0;
    value_1   = '0;
    value_2   = '0;
    operation = 2'd0;
    #2;
    chk("reset_out", out, 64'd0);
    chk("reset_busy", {63'd0, in_operation}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("mult_145x45", 2'd0, 32'd145, 32'd45, 64'h0000_0000_0000_197D);
    issue("div_145_45", 2'd2, 32'd145, 32'd45, {32'd10, 32'd3});
    issue("divu_45_big", 2'd3, 32'd45, 32'hFFFF_FFE0, {32'd45, 32'd0});
    issue("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2,
          {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue("mult_m3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    issue("multu_max2", 2'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    issue("multu_mix", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF,
          64'h7FFF_FFFF_8000_0000);
    issue("mult_mix", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF,
          64'h0000_0000_8000_0000);
    issue("mult_minsq", 2'd0, 32'h8000_0000, 32'h8000_0000,
          64'h4000_0000_0000_0000);
    issue("divu_9_0", 2'd3, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF});
    issue("div_m100_0", 2'd2, 32'hFFFF_FF9C, 32'd0,
          {32'hFFFF_FF9C, 32'hFFFF_FFFF});
    issue("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
          {32'd0, 32'h8000_0000});
    issue("div_100_m7", 2'd2, 32'd100, 32'hFFFF_FFF9,
          {32'd2, 32'hFFFF_FFF2});
    issue("div_m100_m7", 2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
          {32'hFFFF_FFFE, 32'd14});
    issue("divu_max_10", 2'd3, 32'hFFFF_FFFF, 32'd10,
          {32'd5, 32'h1999_9999});
    issue("divu_max_1", 2'd3, 32'hFFFF_FFFF, 32'd1,
          {32'd0, 32'hFFFF_FFFF});

    // Enable pulse and operand change during a division are ignored
    @(negedge clk);
    exp_q.push_back({32'd10, 32'd3});
    name_q.push_back("div_ignore_en");
    enable    = 1'b1;
    operation = 2'd2;
    value_1   = 32'd145;
    value_2   = 32'd45;
    @(negedge clk);
    enable  = 1'b0;
    value_1 = 32'd7;
    value_2 = 32'd1;
    repeat (4) @(negedge clk);
    enable    = 1'b1;
    operation = 2'd0;
    value_1   = 32'd3;
    value_2   = 32'd3;
    @(negedge clk);
    enable = 1'b0;
    wait_idle("div_ignore_en");
    @(negedge clk);

    // Reset mid-division aborts without a result
    @(negedge clk);
    enable    = 1'b1;
    operation = 2'd3;
    value_1   = 32'd1000;
    value_2   = 32'd7;
    @(negedge clk);
    enable = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out", out, 64'd0);
    chk("abort_busy", {63'd0, in_operation}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue("mult_after_rst", 2'd1, 32'd6, 32'd7, 64'd42);
    issue("div_after_rst", 2'd3, 32'd100, 32'd9, {32'd1, 32'd11});

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL pending_results: got %0d left expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
